// File: rtl/past_notes_replay_ctrl_pkg.sv
// Shared definitions for the past-notes replay controller.
//   - default sizing constants for the history depth, note code and hold timer
//   - replay FSM state encoding
package past_notes_replay_ctrl_pkg;

   localparam int DEFAULT_DEPTH  = 5;
   localparam int DEFAULT_NOTE_W = 6;
   localparam int DEFAULT_DUR_W  = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } replay_state_t;

endpackage

// File: rtl/dffr.sv
// Generic W-bit D flip-flop with synchronous active-high reset to zero.
//   clk : clock (rising edge)
//   r   : synchronous reset, clears q
//   d   : next value
//   q   : registered value
module dffr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         r,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (r) q <= '0;
      else   q <= d;
   end

endmodule

// File: rtl/dffre.sv
// Generic W-bit D flip-flop with synchronous active-high reset and load enable.
// Reset has priority over the enable.
//   clk : clock (rising edge)
//   r   : synchronous reset, clears q
//   en  : load enable
//   d   : next value
//   q   : registered value
module dffre #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         r,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (r)       q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/past_notes_replay_ctrl_note_history_shift.sv
// DEPTH-stage shift register of NOTE_W-bit notes. Stage 0 holds the newest note;
// on each enabled edge every stage takes the value of the one below it and the
// oldest entry is discarded.
//   clk    : clock (rising edge)
//   reset  : synchronous active-high reset, clears every stage
//   en     : shift enable
//   din    : note loaded into stage 0
//   q_flat : all stages, stage k at bits [k*NOTE_W +: NOTE_W]
module note_history_shift #(
   parameter int DEPTH  = 5,
   parameter int NOTE_W = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [NOTE_W-1:0]       din,
   output logic [DEPTH*NOTE_W-1:0] q_flat
);

   logic [NOTE_W-1:0] stage_d [DEPTH];
   logic [NOTE_W-1:0] stage_q [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign stage_d[k] = din;
      end else begin : g_tail
         assign stage_d[k] = stage_q[k-1];
      end

      dffre #(.W(NOTE_W)) u_ff (
         .clk (clk),
         .r   (reset),
         .en  (en),
         .d   (stage_d[k]),
         .q   (stage_q[k])
      );

      assign q_flat[k*NOTE_W +: NOTE_W] = stage_q[k];
   end

endmodule

// File: rtl/past_notes_replay_ctrl.sv
// Past-notes replay controller. Captures each new note into a DEPTH-deep
// history and, on request, replays the history oldest-to-newest to the note
// player over a valid/ready handshake, holding each note for hold_cycles
// (minimum 1) cycles after its handshake.
//   clk          : clock (rising edge)
//   reset        : synchronous active-high reset
//   play_enable  : run/pause; low freezes capture, FSM and timer
//   new_note     : one-cycle pulse, note_in valid
//   note_in      : note to capture
//   replay_req   : one-cycle replay request
//   hold_cycles  : per-note hold time, sampled at each handshake
//   player_ready : player accepts out_note
//   out_note     : note being replayed (held after the handshake)
//   out_valid    : out_note offered to the player
//   busy         : FSM not idle
//   fill         : number of valid history entries
//   replay_done  : one-cycle pulse at the end of a replay
//   overrun      : one-cycle pulse when a new note was dropped during replay
module past_notes_replay_ctrl
   import past_notes_replay_ctrl_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int NOTE_W = DEFAULT_NOTE_W,
   parameter int DUR_W  = DEFAULT_DUR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_enable,
   input  logic              new_note,
   input  logic [NOTE_W-1:0] note_in,
   input  logic              replay_req,
   input  logic [DUR_W-1:0]  hold_cycles,
   input  logic              player_ready,
   output logic [NOTE_W-1:0] out_note,
   output logic              out_valid,
   output logic              busy,
   output logic [2:0]        fill,
   output logic              replay_done,
   output logic              overrun
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0]       FILL_MAX   = 3'(DEPTH);
   localparam logic [2:0]       FILL_ONE   = 3'd1;
   localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
   localparam logic [DUR_W-1:0] TIMER_ONE  = DUR_W'(1);

   replay_state_t     state_q, state_d;
   logic [1:0]        state_raw;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DUR_W-1:0]  timer_q, timer_d;
   logic [2:0]        fill_q, fill_d, fill_post;
   logic [NOTE_W-1:0] last_note_q, last_note_d;
   logic              overrun_d;

   logic                    capture;
   logic [DEPTH*NOTE_W-1:0] hist_flat;
   logic [NOTE_W-1:0]       hist [DEPTH];
   logic [NOTE_W-1:0]       hist_sel;
   logic [DUR_W-1:0]        hold_eff;

   // ---------------------------------------------------------------- history
   assign capture = new_note && play_enable && (state_q == IDLE);

   note_history_shift #(
      .DEPTH  (DEPTH),
      .NOTE_W (NOTE_W)
   ) u_history (
      .clk    (clk),
      .reset  (reset),
      .en     (capture),
      .din    (note_in),
      .q_flat (hist_flat)
   );

   always_comb begin
      hist_sel = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         hist[i] = hist_flat[i*NOTE_W +: NOTE_W];
         if (idx_q == i[IDX_W-1:0]) hist_sel = hist[i];
      end
   end

   // -------------------------------------------------------------- registers
   // Everything except overrun advances only while play_enable is high, which
   // gives the freeze/resume behaviour for free.
   dffre #(.W(2)) u_state_ff (
      .clk (clk), .r (reset), .en (play_enable), .d (state_d), .q (state_raw)
   );
   assign state_q = replay_state_t'(state_raw);

   dffre #(.W(IDX_W)) u_idx_ff (
      .clk (clk), .r (reset), .en (play_enable), .d (idx_d), .q (idx_q)
   );

   dffre #(.W(DUR_W)) u_timer_ff (
      .clk (clk), .r (reset), .en (play_enable), .d (timer_d), .q (timer_q)
   );

   dffre #(.W(3)) u_fill_ff (
      .clk (clk), .r (reset), .en (play_enable), .d (fill_d), .q (fill_q)
   );

   dffre #(.W(NOTE_W)) u_note_ff (
      .clk (clk), .r (reset), .en (play_enable), .d (last_note_d), .q (last_note_q)
   );

   assign overrun_d = new_note && play_enable && (state_q != IDLE);

   dffr #(.W(1)) u_overrun_ff (
      .clk (clk), .r (reset), .d (overrun_d), .q (overrun)
   );

   // ------------------------------------------------------------- next state
   assign hold_eff = (hold_cycles == '0) ? TIMER_ONE : hold_cycles;

   // Fill as seen after this cycle's capture, so a replay requested together
   // with a new note starts from the updated oldest entry.
   assign fill_post = (capture && (fill_q != FILL_MAX)) ? (fill_q + FILL_ONE) : fill_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      timer_d     = timer_q;
      fill_d      = fill_q;
      last_note_d = last_note_q;

      unique case (state_q)
         IDLE: begin
            fill_d = fill_post;
            if (replay_req) begin
               if (fill_post != '0) begin
                  idx_d   = IDX_W'(fill_post - FILL_ONE);
                  state_d = ISSUE;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ISSUE: begin
            if (player_ready) begin
               timer_d     = hold_eff;
               last_note_d = hist_sel;
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (timer_q <= TIMER_ONE) begin
               timer_d = '0;
               if (idx_q == '0) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q - IDX_ONE;
                  state_d = ISSUE;
               end
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   assign out_valid   = (state_q == ISSUE) && play_enable;
   assign out_note    = (state_q == ISSUE) ? hist_sel : last_note_q;
   assign busy        = (state_q != IDLE);
   assign replay_done = (state_q == DONE) && play_enable;
   assign fill        = fill_q;

endmodule
